result_demux_1_4: RTL and testbench

- Sequential 1-to-4 result demultiplexer: the distribution end of the selector network. One producer result stream is steered to one of four destination ports.
- Destinations: 0 = GPR write-back, 1 = CR/XER, 2 = LR/CTR, 3 = store buffer.
- Each destination has a one-entry holding register with a valid/ready handshake, so a stalled destination blocks only results addressed to it.
- A saturating stall counter is provided for performance debug.

---
 rtl/result_demux_1_4.sv | 76 +++++++
 tb/tb_result_demux_1_4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/result_demux_1_4.sv
// Sequential 1-to-4 result demultiplexer. One producer result stream is
// steered to GPR write-back (0), CR/XER (1), LR/CTR (2) or the store
// buffer (3). Each destination owns a one-entry holding register with a
// valid/ready handshake, so a stalled destination only blocks results
// addressed to it. A saturating stall counter aids performance debug.
module result_demux_1_4 #(
  parameter int N  = 64,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_sel,
  input  logic [N-1:0]   in_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*N-1:0] out_data,
  output logic           busy,
  output logic [CW-1:0]  stall_cnt
);

  logic [N-1:0]  hold_q [4];
  logic [3:0]    valid_q;
  logic [CW-1:0] stall_q;
  logic          accept;
  logic          stall;

  // The addressed slot can take a word if it is empty or draining this cycle.
  always_comb begin
    in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    stall    = in_valid & ~in_ready;
  end

  // Holding registers: load on accept, clear valid on drain; a load wins over
  // a drain on the same slot, which keeps one word per cycle per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (accept && (in_sel == 2'(i))) begin
          hold_q[i]  <= in_data;
          valid_q[i] <= 1'b1;
        end else if (out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of producer stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // Flatten holding registers onto the output bus and summarise occupancy.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_data[i*N +: N] = hold_q[i];
    end
    out_valid = valid_q;
    busy      = |valid_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_result_demux_1_4.sv
// Bench for result_demux_1_4 (built with CW=4 so saturation is reachable).
// Expected words are queued per channel on accept and retired on drain.
module tb_result_demux_1_4;

  localparam int N  = 64;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_sel;
  logic [N-1:0]   in_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*N-1:0] out_data;
  logic           busy;
  logic [CW-1:0]  stall_cnt;

  always #5 clk = ~clk;

  result_demux_1_4 #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q [4][$];
  logic [N-1:0] last  [4];
  int           m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check outputs against the model mid-cycle, advance the model, then move
  // to just after the next rising edge where the caller drives new inputs.
  task automatic cycle();
    logic [3:0]   v;
    logic         rdy;
    logic [N-1:0] w;
    @(negedge clk);
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = (exp_q[i].size() != 0);
    rdy = !v[in_sel] || out_ready[in_sel];
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("busy", 64'(busy), 64'(|v));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    for (int i = 0; i < 4; i++)
      chk($sformatf("out_data%0d", i), out_data[i*N +: N], last[i]);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        last[i] = '0;
      end
      m_stall = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && out_ready[i]) begin
          w = exp_q[i].pop_front();
          chk($sformatf("drain%0d", i), out_data[i*N +: N], w);
        end
      end
      if (in_valid && rdy) begin
        exp_q[in_sel].push_back(in_data);
        last[in_sel] = in_data;
      end
      if (in_valid && !rdy && m_stall < (2**CW - 1)) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) last[i] = '0;
    m_stall   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    @(posedge clk);
    #1;
    cycle();
    cycle();

    // Reset then idle: in_ready high for every destination
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      cycle();
    end

    // Single route to LR/CTR, hold, then drain
    in_valid = 1'b1; in_sel = 2'd2; in_data = 64'hDEAD_BEEF_0000_0042;
    cycle();
    in_valid = 1'b0;
    chk("route_valid", 64'(out_valid), 64'h4);
    chk("route_data", out_data[2*N +: N], 64'hDEAD_BEEF_0000_0042);
    repeat (5) cycle();
    out_ready = 4'b0100;
    cycle();
    out_ready = 4'b0000;
    chk("route_drained", 64'(out_valid), 64'h0);
    cycle();

    // Back-pressure on CR/XER; other channel still accepts
    in_valid = 1'b1; in_sel = 2'd1; in_data = 64'h1111_2222_3333_4444;
    cycle();
    in_data = 64'h5555;
    repeat (7) cycle();
    chk("bp_stall7", 64'(stall_cnt), 64'd7);
    chk("bp_hold", out_data[1*N +: N], 64'h1111_2222_3333_4444);
    in_sel = 2'd3; in_data = 64'h3333;
    cycle();
    in_valid = 1'b0;
    chk("bp_other", 64'(out_valid), 64'hA);

    // Full throughput on GPR channel after a clean reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      in_data = 64'(k);
      cycle();
      chk("thru_data", out_data[0 +: N], 64'(k));
      chk("thru_valid", 64'(out_valid[0]), 64'd1);
    end
    in_valid = 1'b0;
    cycle();
    chk("thru_stall", 64'(stall_cnt), 64'd0);

    // Saturation of the stall counter
    out_ready = 4'b0000;
    in_valid  = 1'b1; in_sel = 2'd2; in_data = 64'hAA;
    cycle();
    repeat (20) cycle();
    chk("sat", 64'(stall_cnt), 64'd15);

    // Reset with channels 0 and 3 (and 2) full
    in_sel = 2'd0; in_data = 64'hC0;
    cycle();
    in_sel = 2'd3; in_data = 64'hC3;
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    cycle();

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      rst       = ($urandom_range(0, 999) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom};
      out_ready = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
